mdu_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS core, in the EX stage alongside the ALU. It takes the forwarded rs/rt operands from the EX-stage operand muxes and runs mult, multu, div and divu as multi-cycle operations. It also performs mthi/mtlo writes and holds the architectural HI/LO registers. The hazard unit consumes busy/stall_req to stall any following multiply/divide or mfhi/mflo in ID.

---
 rtl/mdu_unit.sv | 135 +++++++++++++
 tb/tb_mdu_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
// The result is computed at issue and only committed to HI/LO on the completion edge.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        hi_n_q, hi_n_d;
    logic [31:0]        lo_n_q, lo_n_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] a_s, b_s, quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
    logic               is_muldiv;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign a_s    = A;
    assign b_s    = B;
    assign quo_s  = a_s / b_s;
    assign rem_s  = a_s % b_s;
    assign quo_u  = A / B;
    assign rem_u  = A % B;

    assign is_muldiv = start & (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign stall_req = busy_q | is_muldiv;

    always_comb begin
        // NOTE: every _d gets its current value first, so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wr_en_d = wr_en_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {hi_n_d, lo_n_d} = (op == OP_MULT) ? prod_s : prod_u;
                            wr_en_d = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_n_d  = (op == OP_DIV) ? rem_s : rem_u;
                            lo_n_d  = (op == OP_DIV) ? quo_s : quo_u;
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            wr_en_d = (B != 32'd0);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (wr_en_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            wr_en_q <= 1'b0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            wr_en_q <= wr_en_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: an edge-numbered reference model checked every cycle,
// plus directed operations with hand-computed HI/LO and busy lengths.
`timescale 1ns/1ps
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .stall_req(stall_req), .HI(hi), .LO(lo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op finishes a fixed number of edges after issue.
    int          edge_n = 0;
    int          m_done = 0;
    bit          chk_en = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_write = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_res_hi = 32'd0, m_res_lo = 32'd0;

    function automatic void model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint          p;
        longint unsigned pu;
        int              xs, ys;
        xs = x;
        ys = y;
        rh = 32'd0;
        rl = 32'd0;
        wr = 1'b1;
        case (o)
            3'd1: begin p = longint'(xs) * longint'(ys); {rh, rl} = p; end
            3'd2: begin pu = 64'(x) * 64'(y); {rh, rl} = pu; end
            3'd3: if (y == 0) wr = 1'b0; else begin rl = xs / ys; rh = xs % ys; end
            3'd4: if (y == 0) wr = 1'b0; else begin rl = x / y; rh = x % y; end
            default: wr = 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            m_pending = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (m_pending) begin
            if (edge_n == m_done) begin
                m_pending = 1'b0;
                if (m_write) begin
                    m_hi = m_res_hi;
                    m_lo = m_res_lo;
                end
            end
        end else if (start) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                model_op(op, a, b, m_res_hi, m_res_lo, m_write);
                m_pending = 1'b1;
                m_done = edge_n + ((op <= 3'd2) ? MULT_N : DIV_N);
            end else if (op == 3'd5) begin
                m_hi = a;
            end else if (op == 3'd6) begin
                m_lo = a;
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_pending);
            check("stall_req", stall_req, m_pending || (start && op >= 3'd1 && op <= 3'd4));
            check("HI", hi, m_hi);
            check("LO", lo, m_lo);
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'd0;
    endtask

    // Counts busy cycles; optionally pulses start with o1/o2 during busy cycle n1/n2.
    task automatic count_busy(input int n1, input logic [2:0] o1, input int n2, input logic [2:0] o2,
                              input logic [31:0] ia, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            start = 1'b0;
            op = 3'd0;
            if (n == n1) begin start = 1'b1; op = o1; a = ia; b = 32'd5; end
            if (n == n2) begin start = 1'b1; op = o2; a = ia; b = 32'd5; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        op = 3'd0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        drive(o, x, y);
        count_busy(0, 3'd0, 0, 3'd0, 32'd0, n);
        check({name, " busy cycles"}, 64'(n), 64'(exp_n));
        check({name, " HI"}, hi, exp_hi);
        check({name, " LO"}, lo, exp_lo);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset stall_req", stall_req, 0);
        check("reset HI", hi, 0);
        check("reset LO", lo, 0);

        run_op("mult",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);

        drive(3'd5, 32'h1234_5678, 32'd0);
        check("mthi HI", hi, 32'h1234_5678);
        check("mthi busy", busy, 0);
        drive(3'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo LO", lo, 32'h9ABC_DEF0);
        check("mtlo busy", busy, 0);

        run_op("divu0", 3'd4, 32'h0000_0007, 32'h0000_0000, 10, 32'h1234_5678, 32'h9ABC_DEF0);

        // 100 / -7 = -14 remainder 2; a mult and a mthi arrive mid-operation.
        drive(3'd3, 32'd100, 32'hFFFF_FFF9);
        count_busy(3, 3'd1, 4, 3'd5, 32'hDEAD_BEEF, n);
        check("div ignore busy cycles", 64'(n), 64'(10));
        check("div ignore HI", hi, 32'h0000_0002);
        check("div ignore LO", lo, 32'hFFFF_FFF2);

        // mtlo in the last busy cycle is dropped; mthi in the first idle cycle is taken.
        drive(3'd1, 32'd3, 32'd4);
        count_busy(5, 3'd6, 0, 3'd0, 32'h0000_FFFF, n);
        check("edge mult busy cycles", 64'(n), 64'(5));
        check("edge mult LO", lo, 32'h0000_000C);
        check("edge mult HI", hi, 32'h0000_0000);
        drive(3'd5, 32'h0000_0ABC, 32'd0);
        check("first idle mthi HI", hi, 32'h0000_0ABC);
        check("first idle mthi LO", lo, 32'h0000_000C);

        // Reset in busy cycle 4 of a div aborts it.
        drive(3'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-abort busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort HI", hi, 0);
        check("abort LO", lo, 0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("no late write HI", hi, 0);
        check("no late write LO", lo, 0);
        check("no late write busy", busy, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
